// File: rtl/dnn_pkg.sv
// Shared types for the ping-pong batch controller: bank state encodings and bank count.
package dnn_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    COMPUTE = 2'd3
  } src_state_t;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WRITING = 2'd1,
    DRAIN   = 2'd2
  } dst_state_t;

  localparam int NBANK = 2;

endpackage

// File: rtl/dnn_bank_ram.sv
// Single bank storage: one write port and one registered read port whose data holds when not reading.
module dnn_bank_ram #(
  parameter int W  = 16,
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rdata_q;

  // Array write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register; cleared so downstream outputs start at zero.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      rdata_q <= {W{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dnn_pingpong_batch.sv
// Double-buffered source/result banks between the stream ports and sample_ctrl.
// Optional src_last framing check enabled by defining DNN_SRC_LAST_CHECK_EN.
module dnn_pingpong_batch
  import dnn_pkg::*;
#(
  parameter int DW  = 16,
  parameter int AW  = 12,
  parameter int XW  = 32,
  parameter int XAW = 12
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           run_i,
  input  logic [AW-1:0]  ss_i,
  input  logic [XAW-1:0] ds_i,
  input  logic           src_valid_i,
  output logic           src_ready_o,
  input  logic           src_last_i,
  input  logic [DW-1:0]  src_data_i,
  output logic           s_init_o,
  input  logic           s_fin_i,
  input  logic           exec_i,
  input  logic [AW-1:0]  ia_i,
  output logic [DW-1:0]  d_o,
  input  logic           outw_i,
  input  logic [XAW-1:0] oa_i,
  input  logic [XW-1:0]  x_i,
  output logic           dst_valid_o,
  input  logic           dst_ready_i,
  output logic           dst_last_o,
  output logic [XW-1:0]  dst_data_o,
  output logic           busy_o,
  output logic           err_o
);

  src_state_t src_st_q [NBANK];
  src_state_t src_st_d [NBANK];
  dst_state_t dst_st_q [NBANK];
  dst_state_t dst_st_d [NBANK];

  logic           fp_q, fp_d, cp_q, cp_d, comp_q, comp_d;
  logic           wp_q, wp_d, dp_q, dp_d, rsel_q, rsel_d, osel_q, osel_d;
  logic [AW-1:0]  src_a_q, src_a_d;
  logic [XAW-1:0] rd_a_q, rd_a_d;
  logic           rd_done_q, rd_done_d;
  logic           src_ready_q, src_ready_d, s_init_q, s_init_d;
  logic           dst_valid_q, dst_valid_d, dst_last_q, dst_last_d;
  logic           busy_q, busy_d, err_q, err_d;

  logic           clr_s, src_fire_s, fill_last_s, any_comp_s, out_take_s, drain_re_s;
  logic [DW-1:0]  srd_s [NBANK];
  logic [XW-1:0]  rrd_s [NBANK];

  assign clr_s      = rst_i | ~run_i;
  assign src_fire_s = src_valid_i & src_ready_q & ~clr_s;

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    dnn_bank_ram #(.W(DW), .AW(AW)) u_src_ram (
      .clk_i   (clk_i),
      .clr_i   (clr_s),
      .we_i    (src_fire_s & (fp_q == 1'(b))),
      .waddr_i (src_a_q),
      .wdata_i (src_data_i),
      .re_i    (exec_i & (comp_q == 1'(b))),
      .raddr_i (ia_i),
      .rdata_o (srd_s[b])
    );
    dnn_bank_ram #(.W(XW), .AW(XAW)) u_dst_ram (
      .clk_i   (clk_i),
      .clr_i   (clr_s),
      .we_i    (outw_i & ~clr_s & (wp_q == 1'(b)) & (dst_st_q[b] == WRITING)),
      .waddr_i (oa_i),
      .wdata_i (x_i),
      .re_i    (drain_re_s & (dp_q == 1'(b))),
      .raddr_i (rd_a_q),
      .rdata_o (rrd_s[b])
    );
  end

  // Bank state machines, pointers and stream handshakes.
  always_comb begin
    src_st_d    = src_st_q;
    dst_st_d    = dst_st_q;
    fp_d        = fp_q;
    cp_d        = cp_q;
    comp_d      = comp_q;
    wp_d        = wp_q;
    dp_d        = dp_q;
    src_a_d     = src_a_q;
    rd_a_d      = rd_a_q;
    rd_done_d   = rd_done_q;
    s_init_d    = 1'b0;
    dst_valid_d = dst_valid_q;
    dst_last_d  = dst_last_q;
    osel_d      = osel_q;
    drain_re_s  = 1'b0;
    busy_d      = 1'b0;
    any_comp_s  = 1'b0;
    for (int b = 0; b < NBANK; b++) begin
      any_comp_s = any_comp_s | (src_st_q[b] == COMPUTE);
    end
    fill_last_s = (src_a_q == ss_i);
    out_take_s  = dst_valid_q & dst_ready_i;

    if (src_fire_s) begin
      if (fill_last_s) begin
        src_st_d[fp_q] = FULL;
        src_a_d        = {AW{1'b0}};
        fp_d           = ~fp_q;
      end else begin
        src_st_d[fp_q] = FILLING;
        src_a_d        = src_a_q + AW'(1);
      end
    end else begin
      src_a_d = src_a_q;
    end

    // Fills and computes both alternate banks, so the oldest FULL bank is always cp.
    if (s_fin_i && any_comp_s) begin
      src_st_d[comp_q] = EMPTY;
      dst_st_d[wp_q]   = DRAIN;
      wp_d             = ~wp_q;
    end else if (!any_comp_s && (src_st_q[cp_q] == FULL) && (dst_st_q[wp_q] == FREE)) begin
      s_init_d         = 1'b1;
      src_st_d[cp_q]   = COMPUTE;
      comp_d           = cp_q;
      cp_d             = ~cp_q;
      dst_st_d[wp_q]   = WRITING;
    end else begin
      s_init_d = 1'b0;
    end

    if (out_take_s && dst_last_q) begin
      dst_st_d[dp_q] = FREE;
      dp_d           = ~dp_q;
      rd_a_d         = {XAW{1'b0}};
      rd_done_d      = 1'b0;
    end else begin
      dp_d = dp_q;
    end

    // The read register doubles as the output stage, so a new read issues only when it empties.
    if ((dst_st_q[dp_q] == DRAIN) && !rd_done_q && (!dst_valid_q || out_take_s)) begin
      drain_re_s  = 1'b1;
      osel_d      = dp_q;
      dst_valid_d = 1'b1;
      dst_last_d  = (rd_a_q == ds_i);
      rd_done_d   = (rd_a_q == ds_i);
      rd_a_d      = rd_a_q + XAW'(1);
    end else if (out_take_s) begin
      dst_valid_d = 1'b0;
      dst_last_d  = 1'b0;
    end else begin
      dst_valid_d = dst_valid_q;
    end

    if (exec_i) begin
      rsel_d = comp_q;
    end else begin
      rsel_d = rsel_q;
    end

    src_ready_d = (src_st_d[fp_d] == EMPTY) || (src_st_d[fp_d] == FILLING);
    for (int b = 0; b < NBANK; b++) begin
      busy_d = busy_d | (src_st_d[b] != EMPTY) | (dst_st_d[b] != FREE);
    end

`ifdef DNN_SRC_LAST_CHECK_EN
    if ((src_fire_s && (src_last_i != fill_last_s)) || (s_fin_i && !any_comp_s)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
`else
    err_d = 1'b0;
`endif
  end

`ifndef DNN_SRC_LAST_CHECK_EN
  logic unused_src_last_s;
  assign unused_src_last_s = src_last_i;
`endif

  // State register with synchronous clear from rst or run low.
  always_ff @(posedge clk_i) begin
    if (clr_s) begin
      for (int b = 0; b < NBANK; b++) begin
        src_st_q[b] <= EMPTY;
        dst_st_q[b] <= FREE;
      end
      fp_q        <= 1'b0;
      cp_q        <= 1'b0;
      comp_q      <= 1'b0;
      wp_q        <= 1'b0;
      dp_q        <= 1'b0;
      rsel_q      <= 1'b0;
      osel_q      <= 1'b0;
      src_a_q     <= {AW{1'b0}};
      rd_a_q      <= {XAW{1'b0}};
      rd_done_q   <= 1'b0;
      src_ready_q <= 1'b0;
      s_init_q    <= 1'b0;
      dst_valid_q <= 1'b0;
      dst_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      src_st_q    <= src_st_d;
      dst_st_q    <= dst_st_d;
      fp_q        <= fp_d;
      cp_q        <= cp_d;
      comp_q      <= comp_d;
      wp_q        <= wp_d;
      dp_q        <= dp_d;
      rsel_q      <= rsel_d;
      osel_q      <= osel_d;
      src_a_q     <= src_a_d;
      rd_a_q      <= rd_a_d;
      rd_done_q   <= rd_done_d;
      src_ready_q <= src_ready_d;
      s_init_q    <= s_init_d;
      dst_valid_q <= dst_valid_d;
      dst_last_q  <= dst_last_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign src_ready_o = src_ready_q;
  assign s_init_o    = s_init_q;
  assign d_o         = srd_s[rsel_q];
  assign dst_valid_o = dst_valid_q;
  assign dst_last_o  = dst_last_q;
  assign dst_data_o  = rrd_s[osel_q];
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule
